muldiv_sequencer: RTL and testbench

- Iterative unsigned multiply/divide engine and sequencer for the HI/LO register pair.
- The ID stage issues MULTU/DIVU to it; the block runs a 32-step shift-add multiply or a restoring divide.
- HI/LO are updated atomically at completion.
- It raises a pipeline stall when a HI/LO reader (MFHI/MFLO) or a second mul/div arrives while an operation is in flight.

---
 rtl/muldiv_sequencer_pkg.sv | 19 +
 rtl/muldiv_sequencer_if.sv | 29 ++
 rtl/muldiv_datapath.sv | 60 ++++++
 rtl/muldiv_sequencer.sv | 106 ++++++++++
 tb/tb_muldiv_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: sequencer states,
// default sizing and the SPECIAL-opcode function codes used by control decode.
package muldiv_sequencer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CNT_W = 6;

    localparam logic [5:0] MULTU_FUNC = 6'h19;
    localparam logic [5:0] DIVU_FUNC  = 6'h1b;
    localparam logic [5:0] MFHI_FUNC  = 6'h10;
    localparam logic [5:0] MFLO_FUNC  = 6'h12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// ID-stage <-> mul/div sequencer bundle: issue strobes, operands, HI/LO
// reader strobe, and the stall/busy/done/HI/LO results.
interface muldiv_sequencer_if
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             rd_hilo;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start_mult, start_div, op_a, op_b, rd_hilo,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  start_mult, start_div, op_a, op_b, rd_hilo,
        output stall, busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_datapath.sv
// Shared 2*WIDTH accumulator: shift-add multiply step or restoring-divide step.
// next_hi/next_lo expose the value the accumulator takes after the current step.
module muldiv_datapath
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_mul,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // acc_q[2W-1:W-1] is the remainder already shifted left with the next dividend bit
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};

        if (is_mul) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
        end

        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (load) begin
            opnd_d = is_mul ? op_a : op_b;
            acc_d  = {{WIDTH{1'b0}}, (is_mul ? op_b : op_a)};
        end else if (step) begin
            acc_d = acc_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign next_hi = acc_step[2*WIDTH-1:WIDTH];
    assign next_lo = acc_step[WIDTH-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// MULTU/DIVU sequencer: accepts ops while idle, steps the datapath WIDTH times,
// commits HI/LO atomically and stalls HI/LO readers or new ops while busy.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input logic               clk,
    input logic               rst,
    muldiv_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic             dp_load, dp_step, dp_is_mul;
    logic [WIDTH-1:0] dp_hi, dp_lo;
    logic             busy;

    // Datapath mode follows the incoming op while idle, the running op otherwise
    assign dp_is_mul = (state_q == ST_IDLE) ? bus.start_mult : (state_q == ST_MUL);

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .load    (dp_load),
        .step    (dp_step),
        .is_mul  (dp_is_mul),
        .op_a    (bus.op_a),
        .op_b    (bus.op_b),
        .next_hi (dp_hi),
        .next_lo (dp_lo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dp_load = 1'b0;
        dp_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_mult) begin
                    dp_load = 1'b1;
                    state_d = ST_MUL;
                    cnt_d   = '0;
                end else if (bus.start_div) begin
                    if (bus.op_b != '0) begin
                        dp_load = 1'b1;
                        state_d = ST_DIV;
                        cnt_d   = '0;
                    end else begin
                        hi_d   = bus.op_a;
                        lo_d   = '1;
                        done_d = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                dp_step = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    hi_d    = dp_hi;
                    lo_d    = dp_lo;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign bus.busy  = busy;
    assign bus.stall = busy & (bus.rd_hilo | bus.start_mult | bus.start_div);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: issued ops push expected HI/LO and busy
// length computed with plain arithmetic; a negedge monitor checks each done pulse.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           busy_len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t         sb[$];
    int           tests    = 0;
    int           fails    = 0;
    bit           mon_en   = 1'b0;
    int           busy_cnt = 0;
    logic [W-1:0] prev_hi, prev_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input bit mul, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [63:0]  p;
        if (mul) begin
            p          = {32'd0, a} * {32'd0, b};
            e.hi       = p[63:32];
            e.lo       = p[31:0];
            e.busy_len = W;
        end else if (b == 0) begin
            e.hi       = a;
            e.lo       = 32'hFFFF_FFFF;
            e.busy_len = 0;
        end else begin
            e.hi       = a % b;
            e.lo       = a / b;
            e.busy_len = W;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!mon_en || rst) begin
            busy_cnt = 0;
            prev_hi  = bus.hi;
            prev_lo  = bus.lo;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("done_without_pending_op", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("hi", bus.hi, e.hi);
                    check("lo", bus.lo, e.lo);
                    check("busy_len", 64'(busy_cnt), 64'(e.busy_len));
                end
                busy_cnt = 0;
            end else begin
                check("hilo_hold", {bus.hi, bus.lo}, {prev_hi, prev_lo});
            end
            prev_hi = bus.hi;
            prev_lo = bus.lo;
        end
    end

    task automatic issue(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start_mult = m;
        bus.start_div  = d;
        bus.op_a       = a;
        bus.op_b       = b;
        if (m || d) sb.push_back(model(m, a, b));
        @(posedge clk);
        #1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_a       = $urandom;
        bus.op_b       = $urandom;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
        check({name, "_done_one_cycle"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           bad;
        bit           seen;
        logic [W-1:0] a, b;
        bit           m;

        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.rd_hilo    = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;

        #1;
        check("reset_hi", bus.hi, 0);
        check("reset_lo", bus.lo, 0);
        check("reset_flags", {bus.busy, bus.done, bus.stall}, 0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done("mul_max");
        issue(1'b1, 1'b0, 32'd3, 32'd5);                 wait_done("mul_3x5");
        issue(1'b0, 1'b1, 32'd100, 32'd7);               wait_done("div_100_7");
        issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1);         wait_done("div_max_1");
        issue(1'b0, 1'b1, 32'd1234, 32'd0);              wait_done("div_by_zero");

        // MFLO held from cycle 3 of a 6*7 multiply
        issue(1'b1, 1'b0, 32'd6, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.rd_hilo = 1'b1;
        bad = 0;
        for (int c = 3; c <= 32; c++) begin
            @(negedge clk);
            if (bus.stall !== 1'b1) bad++;
        end
        check("mflo_stall_cycles_bad", 64'(bad), 0);
        @(negedge clk);
        check("mflo_stall_released", 64'(bus.stall), 0);
        check("mflo_lo_visible", bus.lo, 42);
        check("mflo_done_cycle33", 64'(bus.done), 1);
        bus.rd_hilo = 1'b0;
        @(negedge clk);

        // Second MULTU held on start_mult during DIVU 9/4
        issue(1'b0, 1'b1, 32'd9, 32'd4);
        bus.start_mult = 1'b1;
        bus.op_a       = 32'd2;
        bus.op_b       = 32'd2;
        sb.push_back(model(1'b1, 32'd2, 32'd2));
        bad  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else if (bus.stall !== 1'b1) bad++;
        end
        check("held_mult_stall_bad", 64'(bad), 0);
        check("held_div_done_seen", 64'(seen), 1);
        check("held_no_stall_at_done", 64'(bus.stall), 0);
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        @(negedge clk);
        check("held_mult_accepted", 64'(bus.busy), 1);
        wait_done("held_mult");

        a = $urandom_range(0, 1000);
        b = $urandom;
        issue(1'b1, 1'b1, a, b); wait_done("mult_and_div_together");

        // Asynchronous reset in cycle 10 of a multiply
        issue(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (9) @(posedge clk);
        #2;
        bus.rd_hilo = 1'b1;
        mon_en      = 1'b0;
        rst         = 1'b1;
        #1;
        check("async_rst_hilo", {bus.hi, bus.lo}, 0);
        check("async_rst_flags", {bus.busy, bus.done, bus.stall}, 0);
        sb.delete();
        #1;
        rst         = 1'b0;
        bus.rd_hilo = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.hi != 0 || bus.lo != 0) bad++;
        end
        check("after_rst_no_update", 64'(bad), 0);
        mon_en = 1'b1;
        issue(1'b0, 1'b1, 32'd8, 32'd2); wait_done("div_8_2_after_rst");

        for (int n = 0; n < 16; n++) begin
            m = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            if (n[0]) a = a >> $urandom_range(0, 31);
            issue(m, !m, a, b);
            wait_done("random_op");
        end

        check("scoreboard_drained", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
